// File: rtl/vga_sync_rx.sv
// VGA receiver: registers sync/colour pins, recovers pixel coordinates from the syncs,
// verifies line and frame timing against the parameters and reports lock.
module vga_sync_rx #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vga_hsync,
    input  logic       vga_vsync,
    input  logic [3:0] red,
    input  logic [3:0] green,
    input  logic [3:0] blue,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [3:0] pix_red,
    output logic [3:0] pix_green,
    output logic [3:0] pix_blue,
    output logic       frame_start,
    output logic       locked,
    output logic       err_line,
    output logic       err_frame
);

    // state   | meaning
    // SEARCH  | no timing reference, waiting for a vsync fall
    // ACQUIRE | counting consecutive good frames
    // LOCKED  | timing verified, pixels are delivered
    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    localparam int          H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] H_TOT_L  = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT_L  = 11'(V_TOTAL);
    localparam logic [10:0] H_SYNC_L = 11'(H_SYNC);
    localparam logic [9:0]  H_VS     = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  H_VE     = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0]  V_VS     = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_VE     = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [10:0] TMO_LOAD = 11'(2 * H_TOTAL - 1);
    localparam logic [7:0]  LOCK_N   = 8'(LOCK_FRAMES);

    state_t      state;
    logic        hs_q, hs_qq, vs_q, vs_qq;
    logic [11:0] rgb_q;
    logic [9:0]  hc, vc;
    logic        vs_seen, armed, bad_seen;
    logic [7:0]  good_cnt;
    logic [10:0] tmo_cnt;

    logic        hs_fall, hs_rise, vs_fall, new_frame, checking;
    logic [9:0]  idx, hc_inc, vc_inc;
    logic [10:0] hc_len, vc_len;
    logic        line_err_c, frame_err_c, timeout_c, visible, frame_good;

    always_comb begin
        hs_fall     = hs_qq & ~hs_q;
        hs_rise     = ~hs_qq & hs_q;
        vs_fall     = vs_qq & ~vs_q;
        new_frame   = vs_fall | vs_seen;
        hc_inc      = (hc == 10'h3FF) ? hc : hc + 10'd1;
        vc_inc      = (vc == 10'h3FF) ? vc : vc + 10'd1;
        idx         = hs_fall ? 10'd0 : hc_inc;
        hc_len      = {1'b0, hc} + 11'd1;
        vc_len      = {1'b0, vc} + 11'd1;
        checking    = (state != SEARCH) && armed;
        line_err_c  = checking && ((hs_fall && (hc_len != H_TOT_L)) ||
                                   (hs_rise && (hc_len != H_SYNC_L)));
        frame_err_c = (state != SEARCH) && vs_fall && (vc_len != V_TOT_L);
        timeout_c   = ~hs_fall && (tmo_cnt == 11'd0);
        frame_good  = ~bad_seen && ~line_err_c && ~frame_err_c;
        visible     = locked && (idx >= H_VS) && (idx < H_VE) &&
                      (vc >= V_VS) && (vc < V_VE);
    end

    // Input stage and free-running position counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_q    <= 1'b0;
            hs_qq   <= 1'b0;
            vs_q    <= 1'b0;
            vs_qq   <= 1'b0;
            rgb_q   <= '0;
            hc      <= '0;
            vc      <= '0;
            vs_seen <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            hs_q  <= vga_hsync;
            hs_qq <= hs_q;
            vs_q  <= vga_vsync;
            vs_qq <= vs_q;
            rgb_q <= {red, green, blue};
            hc    <= idx;
            if (hs_fall) begin
                vc      <= new_frame ? 10'd0 : vc_inc;
                vs_seen <= 1'b0;
                tmo_cnt <= TMO_LOAD;
            end else begin
                if (vs_fall)
                    vs_seen <= 1'b1;
                if (tmo_cnt != 11'd0)
                    tmo_cnt <= tmo_cnt - 11'd1;
            end
        end
    end

    // Lock FSM; a timeout overrides any error detected in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            good_cnt  <= '0;
            locked    <= 1'b0;
            err_line  <= 1'b0;
            err_frame <= 1'b0;
            armed     <= 1'b0;
            bad_seen  <= 1'b0;
        end else if (timeout_c) begin
            state     <= SEARCH;
            good_cnt  <= '0;
            locked    <= 1'b0;
            err_line  <= 1'b0;
            err_frame <= 1'b0;
            armed     <= 1'b0;
            bad_seen  <= 1'b0;
        end else begin
            err_line  <= line_err_c;
            err_frame <= frame_err_c;
            if (state == SEARCH || vs_fall)
                bad_seen <= 1'b0;
            else if (line_err_c)
                bad_seen <= 1'b1;
            case (state)
                SEARCH: begin
                    armed <= 1'b0;
                    if (vs_fall) begin
                        state    <= ACQUIRE;
                        good_cnt <= '0;
                    end
                end
                ACQUIRE: begin
                    if (hs_fall)
                        armed <= 1'b1;
                    if (vs_fall) begin
                        if (!frame_good) begin
                            good_cnt <= '0;
                        end else if (good_cnt + 8'd1 == LOCK_N) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + 8'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (hs_fall)
                        armed <= 1'b1;
                    if (line_err_c || frame_err_c) begin
                        state    <= ACQUIRE;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_red     <= '0;
            pix_green   <= '0;
            pix_blue    <= '0;
            frame_start <= 1'b0;
        end else begin
            pix_valid   <= visible;
            pix_x       <= visible ? idx - H_VS : 10'd0;
            pix_y       <= visible ? vc - V_VS : 10'd0;
            pix_red     <= visible ? rgb_q[11:8] : 4'd0;
            pix_green   <= visible ? rgb_q[7:4] : 4'd0;
            pix_blue    <= visible ? rgb_q[3:0] : 4'd0;
            frame_start <= hs_fall && new_frame && (state == LOCKED);
        end
    end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a scaled-down raster (34 clocks x 13 lines)
// so that many complete frames fit in a short run.
module tb_vga_sync_rx;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 8;
    localparam int H_BP     = 6;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int NONE     = -10;

    logic       clk = 1'b0;
    logic       reset;
    logic       vga_hsync, vga_vsync;
    logic [3:0] red, green, blue;
    logic       pix_valid;
    logic [9:0] pix_x, pix_y;
    logic [3:0] pix_red, pix_green, pix_blue;
    logic       frame_start, locked, err_line, err_frame;

    always #20 clk = ~clk;

    vga_sync_rx #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .red(red), .green(green), .blue(blue),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
        .frame_start(frame_start), .locked(locked),
        .err_line(err_line), .err_frame(err_frame)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int   n_eline = 0, n_eframe = 0, n_fstart = 0, n_valid = 0, n_leak = 0, n_long = 0;
    logic el_d = 1'b0, ef_d = 1'b0;

    always @(negedge clk) begin
        if (err_line)    n_eline++;
        if (err_frame)   n_eframe++;
        if (frame_start) n_fstart++;
        if (pix_valid)   n_valid++;
        if (!pix_valid && {pix_red, pix_green, pix_blue} != 12'h000) n_leak++;
        if ((err_line && el_d) || (err_frame && ef_d)) n_long++;
        el_d = err_line;
        ef_d = err_frame;
    end

    logic        pv, pl1, pl2;
    logic [9:0]  px, py;
    logic [11:0] prgb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] src_rgb(input int col, input int row);
        logic [11:0] c;
        if (col == 0 && row == 0)
            c = 12'hA53;
        else if (col == H_ACTIVE - 1 && row == V_ACTIVE - 1)
            c = 12'hFFF;
        else
            c = {col[3:0], row[3:0], 4'h7};
        return c;
    endfunction

    task automatic drive(input logic hs, input logic vs, input logic [11:0] c);
        vga_hsync = hs;
        vga_vsync = vs;
        {red, green, blue} = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 12'hEEE);
        end
    endtask

    // Outputs seen two clocks after pixel 'probe' was driven are the DUT's view of it
    task automatic send_line(input int v, input int len, input int sw, input int probe);
        int  col, row;
        logic vis;
        for (int p = 0; p < len; p++) begin
            @(negedge clk);
            if (p == probe + 1) pl1 = locked;
            if (p == probe + 2) begin
                pv   = pix_valid;
                px   = pix_x;
                py   = pix_y;
                prgb = {pix_red, pix_green, pix_blue};
                pl2  = locked;
            end
            col = p - (H_SYNC + H_BP);
            row = v - (V_SYNC + V_BP);
            vis = (col >= 0) && (col < H_ACTIVE) && (row >= 0) && (row < V_ACTIVE);
            drive(p >= sw, v >= V_SYNC, vis ? src_rgb(col, row) : 12'hEEE);
        end
    endtask

    task automatic send_frame(input int nlines, input int bad_line, input int bad_len,
                              input int bad_sw, input int probe_line, input int probe_p);
        for (int v = 0; v < nlines; v++)
            send_line(v, (v == bad_line) ? bad_len : H_TOTAL,
                      (v == bad_line) ? bad_sw : H_SYNC,
                      (v == probe_line) ? probe_p : NONE);
    endtask

    task automatic good_frame();
        send_frame(V_TOTAL, -1, 0, 0, -1, NONE);
    endtask

    int e0, f0, s0, v0, k0;

    initial begin
        reset = 1'b0;
        drive(1'b1, 1'b1, 12'hEEE);
        pv = 0; pl1 = 0; pl2 = 0; px = 0; py = 0; prgb = 0;
        repeat (3) @(negedge clk);
        check("reset_flags", {pix_valid, frame_start, locked, err_line, err_frame}, 0);
        check("reset_pix", {pix_x, pix_y, pix_red, pix_green, pix_blue}, 0);
        reset = 1'b1;
        idle(5);

        // Acquisition from reset: lock two clocks after the third vsync fall
        good_frame();
        check("t1_unlocked_f1", locked, 0);
        good_frame();
        check("t1_unlocked_f2", locked, 0);
        send_frame(V_TOTAL, -1, 0, 0, 0, 0);
        check("t1_lock_minus1", pl1, 0);
        check("t1_lock", pl2, 1);
        check("t1_no_errs", n_eline + n_eframe, 0);
        check("t1_no_fstart", n_fstart, 0);

        // Pixel delivery while locked
        v0 = n_valid; s0 = n_fstart; k0 = n_leak;
        send_frame(V_TOTAL, -1, 0, 0, V_SYNC + V_BP, H_SYNC + H_BP);
        check("t2_first_valid", pv, 1);
        check("t2_first_xy", {px, py}, 0);
        check("t2_first_rgb", prgb, 12'hA53);
        check("t2_valid_count", n_valid - v0, H_ACTIVE * V_ACTIVE);
        check("t2_frame_start", n_fstart - s0, 1);
        send_frame(V_TOTAL, -1, 0, 0, V_SYNC + V_BP + V_ACTIVE - 1, H_SYNC + H_BP + H_ACTIVE - 1);
        check("t2_last_valid", pv, 1);
        check("t2_last_x", px, H_ACTIVE - 1);
        check("t2_last_y", py, V_ACTIVE - 1);
        check("t2_last_rgb", prgb, 12'hFFF);
        send_frame(V_TOTAL, -1, 0, 0, V_SYNC + V_BP, H_SYNC + H_BP + H_ACTIVE);
        check("t2_past_edge_valid", pv, 0);
        check("t2_past_edge_rgb", prgb, 0);
        check("t2_no_leak", n_leak - k0, 0);

        // One long line while locked
        e0 = n_eline; f0 = n_eframe;
        send_frame(V_TOTAL, 3, H_TOTAL + 1, H_SYNC, -1, NONE);
        check("t3_err_line", n_eline - e0, 1);
        check("t3_no_err_frame", n_eframe - f0, 0);
        check("t3_unlocked", locked, 0);
        good_frame();
        good_frame();
        check("t3_still_unlocked", locked, 0);
        send_frame(V_TOTAL, -1, 0, 0, 0, 0);
        check("t3_relock", pl2, 1);
        check("t3_single_err", n_eline - e0, 1);

        // Short hsync pulse, then a frame with one extra line
        e0 = n_eline; f0 = n_eframe;
        send_frame(V_TOTAL, 3, H_TOTAL, H_SYNC - 1, -1, NONE);
        check("t4_err_line", n_eline - e0, 1);
        check("t4_unlocked_line", locked, 0);
        good_frame();
        good_frame();
        send_frame(V_TOTAL, -1, 0, 0, 0, 0);
        check("t4_relock", pl2, 1);
        e0 = n_eline; f0 = n_eframe;
        send_frame(V_TOTAL + 1, -1, 0, 0, -1, NONE);
        check("t4_locked_before_check", locked, 1);
        good_frame();
        check("t4_err_frame", n_eframe - f0, 1);
        check("t4_no_err_line", n_eline - e0, 0);
        check("t4_unlocked_frame", locked, 0);
        good_frame();
        send_frame(V_TOTAL, -1, 0, 0, 0, 0);
        check("t4_relock2", pl2, 1);

        // Loss of hsync mid-frame
        e0 = n_eline; f0 = n_eframe;
        send_frame(7, -1, 0, 0, -1, NONE);
        idle(2 * H_TOTAL);
        check("t5_timeout_unlocked", locked, 0);
        check("t5_no_err", (n_eline - e0) + (n_eframe - f0), 0);
        good_frame();
        good_frame();
        check("t5_unlocked_f2", locked, 0);
        send_frame(V_TOTAL, -1, 0, 0, 0, 0);
        check("t5_relock_minus1", pl1, 0);
        check("t5_relock", pl2, 1);
        check("t5_no_err_after", (n_eline - e0) + (n_eframe - f0), 0);

        // Asynchronous reset while delivering pixels
        send_frame(V_SYNC + V_BP + 1, -1, 0, 0, -1, NONE);
        send_line(V_SYNC + V_BP + 1, H_SYNC + H_BP + 6, H_SYNC, NONE);
        check("t6_pre_valid", pix_valid, 1);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b1, 12'hEEE);
        #1;
        check("t6_reset_flags", {pix_valid, frame_start, locked, err_line, err_frame}, 0);
        check("t6_reset_pix", {pix_x, pix_y, pix_red, pix_green, pix_blue}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(5);
        good_frame();
        good_frame();
        check("t6_unlocked_f2", locked, 0);
        send_frame(V_TOTAL, -1, 0, 0, 0, 0);
        check("t6_relock_minus1", pl1, 0);
        check("t6_relock", pl2, 1);

        check("err_pulse_width", n_long, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
